// File: rtl/issue_scoreboard.sv
// Single-entry issue stage guarded by a 32-register busy scoreboard.
// Stalls decode on RAW/WAW hazards; writebacks release registers in the same cycle.
module issue_scoreboard #(
  parameter int NUM_WB = 2,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                dec_valid,
  output logic                dec_ready,
  input  logic [4:0]          dec_rs1,
  input  logic [4:0]          dec_rs2,
  input  logic [4:0]          dec_rd,
  input  logic [31:0]         dec_imm,
  input  logic                dec_use_rs1,
  input  logic                dec_use_rs2,
  input  logic                dec_wr_rd,
  output logic                iss_valid,
  input  logic                iss_ready,
  output logic [4:0]          iss_rs1,
  output logic [4:0]          iss_rs2,
  output logic [4:0]          iss_rd,
  output logic [31:0]         iss_imm,
  output logic                iss_wr_rd,
  input  logic [NUM_WB-1:0]   wb_valid,
  input  logic [5*NUM_WB-1:0] wb_rd,
  input  logic                flush,
  output logic [31:0]         busy_regs,
  output logic [CNT_W-1:0]    stall_count
);

  logic [31:0] wb_clr;
  logic [31:0] busy_eff;
  logic [31:0] busy_next;
  logic        hazard;
  logic        accept;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wb_clr = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      if (wb_valid[k] && (wb_rd[5*k +: 5] != 5'd0))
        wb_clr[wb_rd[5*k +: 5]] = 1'b1;
    end
  end

  assign busy_eff = busy_regs & ~wb_clr;

  always_comb begin
    hazard = 1'b0;
    if (dec_use_rs1 && (dec_rs1 != 5'd0) && busy_eff[dec_rs1]) hazard = 1'b1;
    if (dec_use_rs2 && (dec_rs2 != 5'd0) && busy_eff[dec_rs2]) hazard = 1'b1;
    // WAW check keeps at most one outstanding writer per register.
    if (dec_wr_rd && (dec_rd != 5'd0) && busy_eff[dec_rd])     hazard = 1'b1;
  end

  assign dec_ready = !flush && !hazard && (!iss_valid || iss_ready);
  assign accept    = dec_valid && dec_ready;

  // Release first, then squash the flushed entry's claim, then the new claim wins.
  always_comb begin
    busy_next = busy_eff;
    if (flush && iss_valid && iss_wr_rd && (iss_rd != 5'd0))
      busy_next[iss_rd] = 1'b0;
    if (accept && dec_wr_rd && (dec_rd != 5'd0))
      busy_next[dec_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_regs <= '0;
    end else begin
      busy_regs <= busy_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      iss_valid <= 1'b0;
      iss_rs1   <= '0;
      iss_rs2   <= '0;
      iss_rd    <= '0;
      iss_imm   <= '0;
      iss_wr_rd <= 1'b0;
    end else if (flush) begin
      iss_valid <= 1'b0;
    end else if (accept) begin
      iss_valid <= 1'b1;
      iss_rs1   <= dec_rs1;
      iss_rs2   <= dec_rs2;
      iss_rd    <= dec_rd;
      iss_imm   <= dec_imm;
      iss_wr_rd <= dec_wr_rd;
    end else if (iss_ready) begin
      iss_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count <= '0;
    end else if (dec_valid && hazard && !flush && (stall_count != {CNT_W{1'b1}})) begin
      stall_count <= stall_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed bench for issue_scoreboard: accepted instructions are queued as
// expected issue entries and compared when the issue register presents them.
module tb_issue_scoreboard;

  localparam int NUM_WB = 2;
  localparam int CNT_W  = 8;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        wr;
  } ent_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                dec_valid, dec_ready;
  logic [4:0]          dec_rs1, dec_rs2, dec_rd;
  logic [31:0]         dec_imm;
  logic                dec_use_rs1, dec_use_rs2, dec_wr_rd;
  logic                iss_valid, iss_ready;
  logic [4:0]          iss_rs1, iss_rs2, iss_rd;
  logic [31:0]         iss_imm;
  logic                iss_wr_rd;
  logic [NUM_WB-1:0]   wb_valid;
  logic [5*NUM_WB-1:0] wb_rd;
  logic                flush;
  logic [31:0]         busy_regs;
  logic [CNT_W-1:0]    stall_count;

  int   checks = 0;
  int   errors = 0;
  ent_t exp_q[$];

  issue_scoreboard #(.NUM_WB(NUM_WB), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2), .dec_rd(dec_rd), .dec_imm(dec_imm),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2), .dec_wr_rd(dec_wr_rd),
    .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_rd(iss_rd), .iss_imm(iss_imm),
    .iss_wr_rd(iss_wr_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_regs(busy_regs), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic [4:0] rd, input logic [31:0] imm,
                     input logic u1, input logic u2, input logic wr);
    dec_valid = v; dec_rs1 = rs1; dec_rs2 = rs2; dec_rd = rd; dec_imm = imm;
    dec_use_rs1 = u1; dec_use_rs2 = u2; dec_wr_rd = wr;
  endtask

  task automatic check_iss(input string tag);
    check({tag, "_iss_valid"}, 64'(iss_valid), 64'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      check({tag, "_iss_rs1"}, 64'(iss_rs1), 64'(exp_q[0].rs1));
      check({tag, "_iss_rs2"}, 64'(iss_rs2), 64'(exp_q[0].rs2));
      check({tag, "_iss_rd"},  64'(iss_rd),  64'(exp_q[0].rd));
      check({tag, "_iss_imm"}, 64'(iss_imm), 64'(exp_q[0].imm));
      check({tag, "_iss_wr"},  64'(iss_wr_rd), 64'(exp_q[0].wr));
    end
  endtask

  // Inputs are already driven; check dec_ready mid-cycle, step one edge,
  // update the expected issue queue, then check the issue register.
  task automatic cycle(input logic exp_rdy, input string tag);
    ent_t cur;
    logic acc;
    #2;
    check({tag, "_rdy"}, 64'(dec_ready), 64'(exp_rdy));
    cur = '{rs1: dec_rs1, rs2: dec_rs2, rd: dec_rd, imm: dec_imm, wr: dec_wr_rd};
    acc = dec_valid && exp_rdy;
    @(posedge clk);
    if (flush) exp_q.delete();
    else begin
      if (exp_q.size() > 0 && iss_ready) void'(exp_q.pop_front());
      if (acc) exp_q.push_back(cur);
    end
    #1;
    check_iss(tag);
  endtask

  initial begin
    reset = 1'b1; iss_ready = 1'b1; flush = 1'b0; wb_valid = '0; wb_rd = '0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("rst_busy", 64'(busy_regs), 64'h0);
    check("rst_stall", 64'(stall_count), 64'h0);
    check("rst_iss_valid", 64'(iss_valid), 64'h0);
    check("rst_rdy", 64'(dec_ready), 64'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Basic accept, latency 1
    drv(1, 5'd1, 5'd2, 5'd3, 32'h10, 1, 1, 1);
    cycle(1, "acc1");
    check("acc1_busy", 64'(busy_regs), 64'h8);

    // RAW on r3, released by same-cycle writeback
    drv(1, 5'd3, 5'd0, 5'd4, 32'h20, 1, 0, 1);
    cycle(0, "raw_s1");
    cycle(0, "raw_s2");
    check("raw_stall", 64'(stall_count), 64'h2);
    wb_valid = 2'b01; wb_rd = {5'd0, 5'd3};
    cycle(1, "raw_wb");
    wb_valid = '0;
    check("raw_busy", 64'(busy_regs), 64'h10);

    // WAW on r4, writeback on port 1 and re-claim in the same cycle
    drv(1, 5'd0, 5'd0, 5'd4, 32'h30, 0, 0, 1);
    cycle(0, "waw_s");
    check("waw_stall", 64'(stall_count), 64'h3);
    wb_valid = 2'b10; wb_rd = {5'd4, 5'd0};
    cycle(1, "waw_wb");
    wb_valid = '0;
    check("waw_busy", 64'(busy_regs), 64'h10);

    // Backpressure: issue register holds steady, no hazard stall counted
    iss_ready = 1'b0;
    drv(1, 5'd1, 5'd2, 5'd6, 32'h40, 1, 1, 1);
    for (int i = 0; i < 5; i++) cycle(0, "bp_hold");
    check("bp_stall", 64'(stall_count), 64'h3);
    iss_ready = 1'b1;
    cycle(1, "bp_go");
    check("bp_busy", 64'(busy_regs), 64'h50);

    // Flush of an un-taken rd=7 entry
    drv(1, 5'd0, 5'd0, 5'd7, 32'h70, 0, 0, 1);
    cycle(1, "fl_load");
    check("fl_busy_pre", 64'(busy_regs), 64'hD0);
    iss_ready = 1'b0; flush = 1'b1;
    drv(1, 5'd1, 5'd0, 5'd8, 32'h80, 1, 0, 1);
    cycle(0, "fl");
    flush = 1'b0;
    check("fl_busy", 64'(busy_regs), 64'h50);

    // x0 destination, writebacks to a non-busy reg and to x0
    iss_ready = 1'b1;
    wb_valid = 2'b11; wb_rd = {5'd9, 5'd0};
    drv(1, 5'd0, 5'd0, 5'd0, 32'h5, 1, 1, 1);
    cycle(1, "x0");
    check("x0_busy", 64'(busy_regs), 64'h50);
    // Both writeback ports naming r4
    wb_rd = {5'd4, 5'd4};
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, "dualwb");
    wb_valid = '0;
    check("dualwb_busy", 64'(busy_regs), 64'h40);

    // Saturating stall counter: r6 stays busy
    drv(1, 5'd6, 5'd0, 5'd0, 32'h0, 1, 0, 0);
    repeat ((1 << CNT_W) + 3) @(posedge clk);
    #1;
    check("sat_stall", 64'(stall_count), 64'hFF);
    check("sat_rdy", 64'(dec_ready), 64'h0);

    // Release r6, then claim r4..r11
    wb_valid = 2'b01; wb_rd = {5'd0, 5'd6};
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, "wb6");
    wb_valid = '0;
    for (int r = 4; r < 12; r++) begin
      drv(1, 5'd0, 5'd0, 5'(r), 32'(r), 0, 0, 1);
      cycle(1, "fill");
    end
    check("fill_busy", 64'(busy_regs), 64'hFF0);

    // Async reset while stalled with the issue register occupied
    iss_ready = 1'b0;
    drv(1, 5'd4, 5'd0, 5'd0, 32'h0, 1, 0, 0);
    cycle(0, "pre_rst");
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("arst_busy", 64'(busy_regs), 64'h0);
    check("arst_stall", 64'(stall_count), 64'h0);
    check("arst_rdy", 64'(dec_ready), 64'h1);
    check("arst_iss_rd", 64'(iss_rd), 64'h0);
    check("arst_iss_imm", 64'(iss_imm), 64'h0);
    check_iss("arst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/issue_scoreboard.md
Name: issue_scoreboard

Overview:
Sits between the instruction decoder and the execute stage. It accepts decoded register fields and the immediate over a valid/ready handshake, and checks source and destination registers against a 32-bit busy scoreboard. When there is no hazard, it registers the instruction into a single-entry issue stage. Writeback ports release busy registers, and a flush input squashes the un-issued entry.

Parameters:
NUM_WB, 2, number of independent writeback (busy-release) ports.
CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
dec_valid  input  1  decoder presents an instruction
dec_ready  output  1  issue_scoreboard accepts it this cycle
dec_rs1  input  5  source register 1
dec_rs2  input  5  source register 2
dec_rd  input  5  destination register
dec_imm  input  32  decoded immediate
dec_use_rs1  input  1  instruction reads rs1
dec_use_rs2  input  1  instruction reads rs2
dec_wr_rd  input  1  instruction writes rd
iss_valid  output  1  issue register holds an instruction
iss_ready  input  1  execute stage takes it this cycle
iss_rs1, iss_rs2, iss_rd  output  5 each  registered copies
iss_imm  output  32  registered immediate
iss_wr_rd  output  1  registered dec_wr_rd
wb_valid  input  NUM_WB  per-port writeback strobe
wb_rd  input  5*NUM_WB  per-port register; port k occupies bits [5k+4:5k]
flush  input  1  squash un-issued entry and block accept this cycle
busy_regs  output  32  current scoreboard; bit 0 always 0
stall_count  output  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset (async, any time, mid-handshake included): iss_valid=0, iss_* fields=0, busy_regs=0, stall_count=0. dec_ready follows its equation and is 1 while busy_regs=0, iss_valid=0 and flush=0.
- wb_clr[r] = OR over k of (wb_valid[k] && wb_rd[k]==r && r!=0).
- busy_eff = busy_regs & ~wb_clr. A register is released in the same cycle as its writeback.
- hazard = (dec_use_rs1 && dec_rs1!=0 && busy_eff[dec_rs1]) || (dec_use_rs2 && dec_rs2!=0 && busy_eff[dec_rs2]) || (dec_wr_rd && dec_rd!=0 && busy_eff[dec_rd]).
  - The destination check (WAW) guarantees at most one outstanding writer per register.
- dec_ready = !flush && !hazard && (!iss_valid || iss_ready). Combinational; it does not depend on dec_valid.
- accept = dec_valid && dec_ready. On accept, the issue register loads all dec_* fields and iss_valid=1 next cycle (latency 1).
  - Back-to-back accepts every cycle are allowed when iss_ready=1.
- If iss_valid && iss_ready && !accept, then iss_valid=0 next cycle.
- The issue register holds its contents stable while iss_valid && !iss_ready.
- Busy update each cycle, in priority order, set wins last:
  1. Apply wb_clr.
  2. If flush && iss_valid && iss_wr_rd && iss_rd!=0, clear busy[iss_rd].
  3. If accept && dec_wr_rd && dec_rd!=0, set busy[dec_rd].
- Writeback to a non-busy register, or to x0, has no effect.
- Two wb ports naming the same register is legal.
- flush: iss_valid=0 next cycle, regardless of iss_ready. No accept occurs in a flush cycle. Already-issued instructions stay tracked until writeback.
- stall_count increments when dec_valid && hazard && !flush, and saturates at all-ones.
- busy_regs[0] is hard-wired to 0. iss_wr_rd passes through unchanged even for rd=0.

Test Plan:
- Reset release, then dec_valid with rs1=1, rs2=2, rd=3, wr=1, imm=0x10 -> dec_ready=1; next cycle iss_valid=1, iss_rd=3, iss_imm=0x10, busy_regs=0x8.
- RAW: after the above with iss_ready=1, present rs1=3 -> dec_ready=0 and stall_count increments each cycle. Assert wb_valid[0] with wb_rd=3 -> dec_ready=1 in that same cycle; accepted instruction issues the next cycle.
- WAW: rd=5 outstanding, new instruction rd=5 -> stalled. Writeback of 5 and accept of a new rd=5 in the same cycle -> busy_regs[5]=1 afterwards.
- Backpressure: iss_ready=0 with iss_valid=1 -> dec_ready=0 and iss_* fields stable for 5 cycles. Raise iss_ready -> the next instruction is accepted that cycle.
- Flush: issue register holds rd=7, not yet taken; assert flush -> iss_valid=0, busy_regs[7]=0, no accept even with dec_valid=1 and no hazard.
- x0 and saturation: rd=0 with wr=1 -> busy_regs stays 0 and rs1=0 never stalls. Force 2^CNT_W+3 stall cycles -> stall_count holds all-ones.
- Async reset mid-stall with busy_regs=0xFF0 -> outputs zero immediately, before the next clk edge.
